// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: turns single CPU memory requests into timed cycles on an
// 8-bit multiplexed ROM/RAM bus (address phase, wait states, data phase,
// one-cycle response). Writes to ROM are rejected without bus activity.
//
// Ports:
//   clk, reset (async, active-low)
//   req_valid/req_ready/req_space/req_write/req_addr/req_wdata : CPU request
//   rsp_valid/rsp_err/rsp_rdata                                : CPU response
//   bus_out/bus_oe/bus_in/bus_ale/bus_we                       : shared bus
//   rom_cs/ram_cs                                              : chip selects
module mem_bus_ctrl #(
    parameter int unsigned BITS        = 8,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_space,
    input  logic            req_write,
    input  logic [BITS-1:0] req_addr,
    input  logic [BITS-1:0] req_wdata,
    output logic            rsp_valid,
    output logic            rsp_err,
    output logic [BITS-1:0] rsp_rdata,
    output logic [BITS-1:0] bus_out,
    output logic            bus_oe,
    input  logic [BITS-1:0] bus_in,
    output logic            bus_ale,
    output logic            bus_we,
    output logic            rom_cs,
    output logic            ram_cs
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] WAIT_LOAD =
        (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WAIT,
        S_DATA,
        S_RESP
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              space_q, space_d;
    logic              write_q, write_d;
    logic [BITS-1:0]   addr_q, addr_d;
    logic [BITS-1:0]   wdata_q, wdata_d;
    logic [BITS-1:0]   rdata_q, rdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic [BITS-1:0]   bus_out_q, bus_out_d;
    logic              bus_oe_q, bus_oe_d;
    logic              bus_ale_q, bus_ale_d;
    logic              bus_we_q, bus_we_d;
    logic              rom_cs_q, rom_cs_d;
    logic              ram_cs_q, ram_cs_d;

    // State and registered outputs; reset drops every bus control at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            space_q     <= 1'b0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            bus_out_q   <= '0;
            bus_oe_q    <= 1'b0;
            bus_ale_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            rom_cs_q    <= 1'b0;
            ram_cs_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            space_q     <= space_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            bus_out_q   <= bus_out_d;
            bus_oe_q    <= bus_oe_d;
            bus_ale_q   <= bus_ale_d;
            bus_we_q    <= bus_we_d;
            rom_cs_q    <= rom_cs_d;
            ram_cs_q    <= ram_cs_d;
        end
    end

    // Next state, then outputs decoded from the next state so that the
    // registered bus signals line up with the state they belong to.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        space_d     = space_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        bus_out_d   = '0;
        bus_oe_d    = 1'b0;
        bus_ale_d   = 1'b0;
        bus_we_d    = 1'b0;
        rom_cs_d    = 1'b0;
        ram_cs_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    space_d = req_space;
                    write_d = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    // ROM write: straight to an error response, bus untouched
                    state_d = (req_write && !req_space) ? S_RESP : S_ADDR;
                end
            end
            S_ADDR: begin
                if (WAIT_CYCLES > 0) begin
                    state_d = S_WAIT;
                    cnt_d   = WAIT_LOAD;
                end else begin
                    state_d = S_DATA;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DATA: begin
                if (!write_q) begin
                    rdata_d = bus_in;
                end
                state_d = S_RESP;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        case (state_d)
            S_ADDR: begin
                bus_ale_d = 1'b1;
                bus_oe_d  = 1'b1;
                bus_out_d = addr_d;
                rom_cs_d  = !space_d;
                ram_cs_d  = space_d;
            end
            S_WAIT, S_DATA: begin
                rom_cs_d = !space_d;
                ram_cs_d = space_d;
                if (write_d) begin
                    bus_out_d = wdata_d;
                    bus_oe_d  = 1'b1;
                    bus_we_d  = 1'b1;
                end
            end
            S_RESP: begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = write_d && !space_d;
            end
            default: ;
        endcase
    end

    assign req_ready = (state_q == S_IDLE) && reset;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rdata_q;
    assign bus_out   = bus_out_q;
    assign bus_oe    = bus_oe_q;
    assign bus_ale   = bus_ale_q;
    assign bus_we    = bus_we_q;
    assign rom_cs    = rom_cs_q;
    assign ram_cs    = ram_cs_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Bench for mem_bus_ctrl: two instances (WAIT_CYCLES = 1 and 0) with
// independent stimulus, a transaction-phase reference model, and directed
// literal checks followed by randomized traffic.
module tb_mem_bus_ctrl;

    typedef struct packed {
        logic       ready;
        logic       rv;
        logic       re;
        logic [7:0] rd;
        logic [7:0] out;
        logic       oe;
        logic       ale;
        logic       we;
        logic       rom;
        logic       ram;
    } obs_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic       req_valid [2];
    logic       req_space [2];
    logic       req_write [2];
    logic [7:0] req_addr  [2];
    logic [7:0] req_wdata [2];
    logic [7:0] bus_in    [2];
    logic       req_ready [2];
    logic       rsp_valid [2];
    logic       rsp_err   [2];
    logic [7:0] rsp_rdata [2];
    logic [7:0] bus_out   [2];
    logic       bus_oe    [2];
    logic       bus_ale   [2];
    logic       bus_we    [2];
    logic       rom_cs    [2];
    logic       ram_cs    [2];

    mem_bus_ctrl #(.BITS(8), .WAIT_CYCLES(1)) u_dut_w1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_space(req_space[0]), .req_write(req_write[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_err(rsp_err[0]), .rsp_rdata(rsp_rdata[0]),
        .bus_out(bus_out[0]), .bus_oe(bus_oe[0]), .bus_in(bus_in[0]),
        .bus_ale(bus_ale[0]), .bus_we(bus_we[0]),
        .rom_cs(rom_cs[0]), .ram_cs(ram_cs[0])
    );

    mem_bus_ctrl #(.BITS(8), .WAIT_CYCLES(0)) u_dut_w0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_space(req_space[1]), .req_write(req_write[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_err(rsp_err[1]), .rsp_rdata(rsp_rdata[1]),
        .bus_out(bus_out[1]), .bus_oe(bus_oe[1]), .bus_in(bus_in[1]),
        .bus_ale(bus_ale[1]), .bus_we(bus_we[1]),
        .rom_cs(rom_cs[1]), .ram_cs(ram_cs[1])
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
        total_cnt++;
        if (act === expv) pass_cnt++;
        else $display("FAIL %s: got %h want %h", name, act, expv);
    endtask

    function automatic int wcfg(int i);
        return (i == 0) ? 1 : 0;
    endfunction

    // Reference model: each transaction is a fixed sequence of phases
    // counted from the accepting edge.
    int         e = 0;
    bit         busy  [2];
    bit         acc   [2];
    int         a     [2];
    int         len   [2];
    bit         m_sp  [2];
    bit         m_wr  [2];
    bit         m_err [2];
    logic [7:0] m_ad  [2];
    logic [7:0] m_wd  [2];
    logic [7:0] m_rd  [2];
    obs_t       exp_o [2];

    initial begin
        int w;
        int ph;
        for (int i = 0; i < 2; i++) begin
            busy[i] = 0; acc[i] = 0; a[i] = 0; len[i] = 0; m_rd[i] = '0; exp_o[i] = '0;
        end
        forever begin
            @(posedge clk);
            e = e + 1;
            for (int i = 0; i < 2; i++) begin
                w = wcfg(i);
                acc[i] = 0;
                if (!reset) begin
                    busy[i]  = 0;
                    m_rd[i]  = '0;
                    exp_o[i] = '0;
                end else begin
                    if (busy[i] && !m_err[i] && !m_wr[i] && (e - 1 - a[i]) == w + 1)
                        m_rd[i] = bus_in[i];
                    if (busy[i] && (e - 1 - a[i]) >= len[i]) busy[i] = 0;
                    if (!busy[i] && req_valid[i]) begin
                        busy[i]  = 1;
                        acc[i]   = 1;
                        a[i]     = e;
                        m_sp[i]  = req_space[i];
                        m_wr[i]  = req_write[i];
                        m_ad[i]  = req_addr[i];
                        m_wd[i]  = req_wdata[i];
                        m_err[i] = req_write[i] && !req_space[i];
                        len[i]   = m_err[i] ? 1 : w + 3;
                    end
                    exp_o[i]    = '0;
                    exp_o[i].rd = m_rd[i];
                    ph = e - a[i];
                    if (!busy[i] || ph >= len[i]) begin
                        exp_o[i].ready = 1'b1;
                    end else if (m_err[i]) begin
                        exp_o[i].rv = 1'b1;
                        exp_o[i].re = 1'b1;
                    end else if (ph == 0) begin
                        exp_o[i].ale = 1'b1;
                        exp_o[i].oe  = 1'b1;
                        exp_o[i].out = m_ad[i];
                        exp_o[i].rom = !m_sp[i];
                        exp_o[i].ram = m_sp[i];
                    end else if (ph <= w + 1) begin
                        exp_o[i].rom = !m_sp[i];
                        exp_o[i].ram = m_sp[i];
                        if (m_wr[i]) begin
                            exp_o[i].oe  = 1'b1;
                            exp_o[i].we  = 1'b1;
                            exp_o[i].out = m_wd[i];
                        end
                    end else begin
                        exp_o[i].rv = 1'b1;
                    end
                end
            end
        end
    end

    // Compare process: every cycle, both instances, away from the active edge.
    int rsp_cnt  [2];
    int ale_last [2];
    int ale_prev [2];

    initial begin
        obs_t act;
        obs_t want;
        for (int i = 0; i < 2; i++) begin
            rsp_cnt[i] = 0; ale_last[i] = 0; ale_prev[i] = 0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                act.ready = req_ready[i];
                act.rv    = rsp_valid[i];
                act.re    = rsp_err[i];
                act.rd    = rsp_rdata[i];
                act.out   = bus_out[i];
                act.oe    = bus_oe[i];
                act.ale   = bus_ale[i];
                act.we    = bus_we[i];
                act.rom   = rom_cs[i];
                act.ram   = ram_cs[i];
                want = reset ? exp_o[i] : '0;
                chk($sformatf("cycle_dut%0d_e%0d", i, e), 32'(act), 32'(want));
                if (rsp_valid[i] === 1'b1) rsp_cnt[i]++;
                if (bus_ale[i] === 1'b1) begin
                    ale_prev[i] = ale_last[i];
                    ale_last[i] = e;
                end
            end
        end
    end

    task automatic drive(int i, bit sp, bit wr, logic [7:0] ad, logic [7:0] wd);
        req_valid[i] = 1'b1;
        req_space[i] = sp;
        req_write[i] = wr;
        req_addr[i]  = ad;
        req_wdata[i] = wd;
    endtask

    task automatic wait_acc(int i, output int ae);
        bit got;
        got = 0;
        ae  = 0;
        for (int n = 0; n < 40 && !got; n++) begin
            @(posedge clk);
            #1;
            if (acc[i]) begin
                got = 1;
                ae  = e;
            end
        end
        total_cnt++;
        if (got) pass_cnt++;
        else $display("FAIL accept_timeout_dut%0d: got no accept want accept within 40 cycles", i);
    endtask

    task automatic rand_req(int i);
        drive(i, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
              8'($urandom), 8'($urandom));
    endtask

    initial begin
        int ae, ae1, ae2, rcnt0, rom_hi;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0; req_space[i] = 1'b0; req_write[i] = 1'b0;
            req_addr[i] = '0; req_wdata[i] = '0; bus_in[i] = '0;
        end

        // Reset state, then release
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(req_ready[0]), 32'd0);
        chk("rst_rdata", 32'(rsp_rdata[0]), 32'd0);
        #2 reset = 1'b1;
        #1;
        chk("ready_after_reset_w1", 32'(req_ready[0]), 32'd1);
        chk("ready_after_reset_w0", 32'(req_ready[1]), 32'd1);

        // W=1 RAM read 0x3C, bus returns 0xA5
        @(negedge clk); #1;
        bus_in[0] = 8'hA5;
        drive(0, 1'b1, 1'b0, 8'h3C, 8'h00);
        wait_acc(0, ae);
        req_valid[0] = 1'b0;
        @(negedge clk);
        chk("rd_addr_ale", 32'(bus_ale[0]), 32'd1);
        chk("rd_addr_out", 32'(bus_out[0]), 32'h3C);
        chk("rd_addr_ramcs", 32'(ram_cs[0]), 32'd1);
        chk("rd_addr_romcs", 32'(rom_cs[0]), 32'd0);
        repeat (3) @(negedge clk);
        chk("rd_rsp_valid", 32'(rsp_valid[0]), 32'd1);
        chk("rd_rsp_err", 32'(rsp_err[0]), 32'd0);
        chk("rd_rsp_rdata", 32'(rsp_rdata[0]), 32'hA5);
        @(negedge clk);
        chk("rd_ready_back", 32'(req_ready[0]), 32'd1);
        chk("rd_rsp_pulse", 32'(rsp_valid[0]), 32'd0);

        // W=1 RAM write 0x10 <- 0x5A; rdata must keep 0xA5
        #1;
        bus_in[0] = 8'h33;
        drive(0, 1'b1, 1'b1, 8'h10, 8'h5A);
        wait_acc(0, ae);
        req_valid[0] = 1'b0;
        @(negedge clk);
        chk("wr_addr_out", 32'(bus_out[0]), 32'h10);
        chk("wr_addr_we", 32'(bus_we[0]), 32'd0);
        @(negedge clk);
        chk("wr_wait_out", 32'(bus_out[0]), 32'h5A);
        chk("wr_wait_we", 32'(bus_we[0]), 32'd1);
        @(negedge clk);
        chk("wr_data_out", 32'(bus_out[0]), 32'h5A);
        chk("wr_data_we", 32'(bus_we[0]), 32'd1);
        @(negedge clk);
        chk("wr_rsp_valid", 32'(rsp_valid[0]), 32'd1);
        chk("wr_rsp_rdata", 32'(rsp_rdata[0]), 32'hA5);

        // ROM write 0x00: rejected, no bus activity
        @(negedge clk); #1;
        drive(0, 1'b0, 1'b1, 8'h00, 8'hEE);
        wait_acc(0, ae);
        req_valid[0] = 1'b0;
        @(negedge clk);
        chk("romwr_rsp", 32'({rsp_valid[0], rsp_err[0]}), 32'b11);
        chk("romwr_nobus", 32'({bus_ale[0], rom_cs[0], ram_cs[0], bus_we[0]}), 32'd0);
        chk("romwr_rdata", 32'(rsp_rdata[0]), 32'hA5);
        @(negedge clk);
        chk("romwr_ready", 32'(req_ready[0]), 32'd1);
        chk("romwr_nobus2", 32'({bus_ale[0], rom_cs[0], ram_cs[0], bus_we[0]}), 32'd0);

        // Reset asserted in the WAIT cycle of a RAM write
        #1;
        drive(0, 1'b1, 1'b1, 8'h44, 8'h99);
        wait_acc(0, ae);
        req_valid[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_wait_we", 32'(bus_we[0]), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_bus", 32'({bus_out[0], bus_oe[0], bus_ale[0], bus_we[0], ram_cs[0], rom_cs[0]}), 32'd0);
        chk("mid_rst_rsp", 32'(rsp_valid[0]), 32'd0);
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_ready_w1", 32'(req_ready[0]), 32'd1);
        chk("mid_rst_ready_w0", 32'(req_ready[1]), 32'd1);

        // W=0 ROM read 0xFF, bus returns 0x42
        @(negedge clk); #1;
        bus_in[1] = 8'h42;
        drive(1, 1'b0, 1'b0, 8'hFF, 8'h00);
        wait_acc(1, ae);
        req_valid[1] = 1'b0;
        rom_hi = 0;
        @(negedge clk);
        chk("w0_addr_out", 32'(bus_out[1]), 32'hFF);
        if (rom_cs[1] === 1'b1) rom_hi++;
        @(negedge clk);
        if (rom_cs[1] === 1'b1) rom_hi++;
        @(negedge clk);
        if (rom_cs[1] === 1'b1) rom_hi++;
        chk("w0_rsp_valid", 32'(rsp_valid[1]), 32'd1);
        chk("w0_rsp_rdata", 32'(rsp_rdata[1]), 32'h42);
        @(negedge clk);
        if (rom_cs[1] === 1'b1) rom_hi++;
        chk("w0_romcs_cycles", 32'(rom_hi), 32'd2);

        // Back-to-back on W=1: second request changed while busy
        #1;
        rcnt0 = rsp_cnt[0];
        bus_in[0] = 8'h5C;
        drive(0, 1'b1, 1'b0, 8'h21, 8'h00);
        wait_acc(0, ae1);
        drive(0, 1'b1, 1'b1, 8'h22, 8'h77);
        wait_acc(0, ae2);
        req_valid[0] = 1'b0;
        chk("b2b_accept_gap", 32'(ae2 - ae1), 32'd5);
        repeat (8) @(negedge clk);
        chk("b2b_rsp_count", 32'(rsp_cnt[0] - rcnt0), 32'd2);
        chk("b2b_ale_gap", 32'(ale_last[0] - ale_prev[0]), 32'd5);
        chk("b2b_rdata", 32'(rsp_rdata[0]), 32'h5C);

        // Randomized traffic on both instances
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk); #1;
            for (int i = 0; i < 2; i++) begin
                bus_in[i] = 8'($urandom);
                if (req_valid[i]) begin
                    if (acc[i]) begin
                        if ($urandom_range(1, 0) == 1) rand_req(i);
                        else req_valid[i] = 1'b0;
                    end
                end else if ($urandom_range(2, 0) == 0) begin
                    rand_req(i);
                end
            end
        end
        req_valid[0] = 1'b0;
        req_valid[1] = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
